// File: rtl/dmx8_32bits_reg_pkg.sv
// Shared constants and types for the registered 1-to-8 word distributor.
package dmx8_32bits_reg_pkg;

  localparam int NUM_CH        = 8;
  localparam int SEL_W         = 3;
  localparam int DEFAULT_WIDTH = 32;

  typedef logic [SEL_W-1:0]  ch_sel_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;

endpackage

// File: rtl/dmx8_32bits_reg_dec3to8.sv
// 3-to-8 one-hot decoder gated by an enable; produces per-channel write strobes.
module dmx8_32bits_reg_dec3to8
  import dmx8_32bits_reg_pkg::*;
(
  input  logic    en,
  input  ch_sel_t sel,
  output ch_mask_t strobe
);

  always_comb begin
    strobe = '0;
    if (en) strobe[sel] = 1'b1;
  end

endmodule

// File: rtl/dmx8_32bits_reg.sv
// Registered 1-to-8 distributor: one word per handshake goes to a selected or
// round-robin channel register, each drained by its own valid/ack pair.
module dmx8_32bits_reg
  import dmx8_32bits_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  input  logic             auto_inc,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [7:0]       ack,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic [7:0]       vld,
  output logic [2:0]       ptr
);

  logic [WIDTH-1:0] y_q [NUM_CH];
  ch_mask_t         vld_q;
  ch_sel_t          ptr_q;
  ch_sel_t          target;
  ch_mask_t         wr_strobe;
  logic             accept;

  assign target = auto_inc ? ptr_q : {s2, s1, s0};

  // A full channel still accepts when its consumer is draining it this cycle.
  assign i_ready = ~vld_q[target] | ack[target];
  assign accept  = i_valid & i_ready;

  dmx8_32bits_reg_dec3to8 u_dec (
    .en    (accept),
    .sel   (target),
    .strobe(wr_strobe)
  );

  // A write takes priority over a same-channel ack so the flag stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) y_q[k] <= '0;
      vld_q <= '0;
      ptr_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_strobe[k]) begin
          y_q[k]   <= d;
          vld_q[k] <= 1'b1;
        end else if (ack[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
      if (accept && auto_inc) ptr_q <= ptr_q + 3'd1;
    end
  end

  assign y0  = y_q[0];
  assign y1  = y_q[1];
  assign y2  = y_q[2];
  assign y3  = y_q[3];
  assign y4  = y_q[4];
  assign y5  = y_q[5];
  assign y6  = y_q[6];
  assign y7  = y_q[7];
  assign vld = vld_q;
  assign ptr = ptr_q;

endmodule

// File: tb/tb_dmx8_32bits_reg.sv
// Scoreboard bench for dmx8_32bits_reg: directed scenarios plus random traffic
// checked against an array-based channel model.
module tb_dmx8_32bits_reg;

  typedef struct packed {
    logic [7:0][31:0] y;
    logic [7:0]       vld;
    logic [2:0]       ptr;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d;
  logic        s2, s1, s0;
  logic        auto_inc;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  ack;
  logic [31:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0]  vld;
  logic [2:0]  ptr;

  logic [7:0][31:0] dut_y;

  int pass_cnt  = 0;
  int total_cnt = 0;

  snap_t state_q[$];
  logic  ready_q[$];

  logic [31:0] m_y [8];
  bit          m_vld [8];
  int          m_ptr;

  dmx8_32bits_reg dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .s2      (s2),
    .s1      (s1),
    .s0      (s0),
    .auto_inc(auto_inc),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .ack     (ack),
    .y0      (y0),
    .y1      (y1),
    .y2      (y2),
    .y3      (y3),
    .y4      (y4),
    .y5      (y5),
    .y6      (y6),
    .y7      (y7),
    .vld     (vld),
    .ptr     (ptr)
  );

  assign dut_y = {y7, y6, y5, y4, y3, y2, y1, y0};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Drive one cycle, then advance the channel model by the rules and queue expectations.
  task automatic applyStimulus(input bit rst, input logic [31:0] dv, input int sel,
                               input bit auto, input bit iv, input logic [7:0] ak);
    int  t;
    bit  rdy;
    snap_t s;
    @(negedge clk);
    reset    = rst;
    d        = dv;
    {s2, s1, s0} = sel[2:0];
    auto_inc = auto;
    i_valid  = iv;
    ack      = ak;
    t   = auto ? m_ptr : sel;
    rdy = !m_vld[t] || ak[t];
    ready_q.push_back(rdy);
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        m_y[k]   = 32'd0;
        m_vld[k] = 1'b0;
      end
      m_ptr = 0;
    end else begin
      for (int k = 0; k < 8; k++)
        if (ak[k]) m_vld[k] = 1'b0;
      if (iv && rdy) begin
        m_y[t]   = dv;
        m_vld[t] = 1'b1;
        if (auto) m_ptr = (m_ptr + 1) % 8;
      end
    end
    for (int k = 0; k < 8; k++) begin
      s.y[k]   = m_y[k];
      s.vld[k] = m_vld[k];
    end
    s.ptr = 3'(m_ptr);
    state_q.push_back(s);
  endtask

  // Handshake monitor: i_ready is compared mid-cycle, once inputs have settled.
  initial begin
    logic exp_r;
    forever begin
      @(negedge clk);
      #2;
      if (ready_q.size() > 0) begin
        exp_r = ready_q.pop_front();
        checkOutput("i_ready", {31'd0, i_ready}, {31'd0, exp_r});
      end
    end
  end

  // Register monitor: compares channel registers, flags and pointer after each edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        e = state_q.pop_front();
        for (int k = 0; k < 8; k++)
          checkOutput($sformatf("y%0d", k), dut_y[k], e.y[k]);
        checkOutput("vld", {24'd0, vld}, {24'd0, e.vld});
        checkOutput("ptr", {29'd0, ptr}, {29'd0, e.ptr});
      end
    end
  end

  initial begin
    reset = 1'b1; d = '0; {s2, s1, s0} = 3'd0;
    auto_inc = 1'b0; i_valid = 1'b0; ack = '0;
    for (int k = 0; k < 8; k++) begin
      m_y[k] = 32'd0;
      m_vld[k] = 1'b0;
    end
    m_ptr = 0;
    repeat (2) @(posedge clk);

    // Reset state, then a single select-routed write to channel 5.
    applyStimulus(1, 0, 0, 0, 0, 8'h00);
    applyStimulus(0, 32'hDEADBEEF, 5, 0, 1, 8'h00);
    applyStimulus(0, 0, 0, 0, 0, 8'h00);

    // Stall on a full channel, then pass-through with a same-cycle ack.
    applyStimulus(0, 32'h1234, 5, 0, 1, 8'h00);
    applyStimulus(0, 32'h1234, 5, 0, 1, 8'h20);
    applyStimulus(0, 0, 0, 0, 0, 8'h00);

    // Round-robin with ack held: nine accepts wrap the pointer.
    applyStimulus(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) applyStimulus(0, i, 0, 1, 1, 8'hFF);
    applyStimulus(0, 0, 0, 0, 0, 8'h00);

    // Fill every channel, then drain 0 and 7 together; data must remain.
    applyStimulus(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) applyStimulus(0, 32'hA000_0000 + i, 0, 1, 1, 8'h00);
    applyStimulus(0, 32'hFFFF_FFFF, 3, 0, 1, 8'h00);
    applyStimulus(0, 0, 0, 0, 0, 8'h81);

    // Reset during an in-flight accept drops everything.
    applyStimulus(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h5000 + i, 0, 1, 1, 8'h00);
    applyStimulus(1, 32'hCAFE_F00D, 2, 0, 1, 8'h04);
    applyStimulus(0, 0, 2, 0, 0, 8'h00);

    // Pointer ignores select in auto mode, and holds once auto mode is dropped.
    applyStimulus(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(0, i, 0, 1, 1, 8'hFF);
    applyStimulus(0, 32'h3333_3333, 6, 1, 1, 8'hFF);
    applyStimulus(0, 32'h6666_6666, 6, 0, 1, 8'hFF);
    applyStimulus(0, 0, 0, 0, 0, 8'h00);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 49) == 0), $urandom, $urandom_range(0, 7),
                    $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                    8'($urandom & $urandom));

    applyStimulus(0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 10 && (state_q.size() > 0 || ready_q.size() > 0); i++)
      @(posedge clk);
    #3;
    if (state_q.size() > 0 || ready_q.size() > 0) begin
      total_cnt++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", state_q.size() + ready_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
